// File: rtl/gshare_spec_predictor_if.sv
// Fetch/execute-side bundle for the gshare predictor.
// The pipeline (master) presents fetch and resolve information; the predictor
// (slave) returns the prediction, its history snapshot and statistics.
interface gshare_spec_predictor_if #(
  parameter int GHR_LEN = 4
);
  // Fetch-side lookup
  logic               fetch_valid;
  logic               fetch_is_br;
  logic [31:0]        pc_fetch;
  logic               pred_taken;
  logic [GHR_LEN-1:0] pred_hist;

  // Execute-side resolve
  logic               exe_valid;
  logic [31:0]        pc_exe;
  logic [GHR_LEN-1:0] exe_hist;
  logic               exe_pred_taken;
  logic               br_en;
  logic               mis_predict;

  // Statistics
  logic [31:0]        br_count;
  logic [31:0]        mispred_count;

  modport master (
    output fetch_valid, fetch_is_br, pc_fetch,
    output exe_valid, pc_exe, exe_hist, exe_pred_taken, br_en,
    input  pred_taken, pred_hist, mis_predict, br_count, mispred_count
  );

  modport slave (
    input  fetch_valid, fetch_is_br, pc_fetch,
    input  exe_valid, pc_exe, exe_hist, exe_pred_taken, br_en,
    output pred_taken, pred_hist, mis_predict, br_count, mispred_count
  );
endinterface

// File: rtl/gshare_spec_predictor.sv
// gshare direction predictor with a speculative global history register.
// Lookup: PHT[pc slice ^ GHR] gives the direction in the same cycle.
// Resolve: the history snapshot carried with the branch rebuilds the write
// index for training and, on a mispredict, repairs the GHR.
module gshare_spec_predictor #(
  parameter int IDX_OFFSET = 6,
  parameter int IDX_LEN    = 4,
  parameter int GHR_LEN    = 4,
  parameter int CTR_BITS   = 2
) (
  input  logic clk,
  input  logic rst,
  gshare_spec_predictor_if.slave bus
);

  localparam int                PHT_DEPTH = 1 << IDX_LEN;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  // Weakly not-taken: one below the taken threshold (0 for 1-bit counters)
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [31:0]       CNT_MAX   = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // History is zero-extended to the index width before hashing with the PC.
  function automatic logic [IDX_LEN-1:0] pht_index(
    input logic [IDX_LEN-1:0] pc_slice,
    input logic [GHR_LEN-1:0] hist
  );
    pht_index = pc_slice ^ IDX_LEN'(hist);
  endfunction

  // Two-way saturating counter step.
  function automatic logic [CTR_BITS-1:0] ctr_train(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    if (taken) begin
      ctr_train = (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1'b1);
    end else begin
      ctr_train = (ctr == CTR_ZERO) ? ctr : ctr - CTR_BITS'(1'b1);
    end
  endfunction

  // Shift a new outcome into the youngest history bit; works for GHR_LEN = 1.
  function automatic logic [GHR_LEN-1:0] ghr_shift(
    input logic [GHR_LEN-1:0] hist,
    input logic               new_bit
  );
    ghr_shift = (hist << 1) | GHR_LEN'(new_bit);
  endfunction

  // Statistics counter that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    sat_inc32 = (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CTR_BITS-1:0] pht_q [PHT_DEPTH];
  logic [GHR_LEN-1:0]  ghr_q;
  logic [GHR_LEN-1:0]  ghr_d;
  logic [31:0]         br_count_q;
  logic [31:0]         br_count_d;
  logic [31:0]         mispred_count_q;
  logic [31:0]         mispred_count_d;

  logic [IDX_LEN-1:0]  rd_idx_s;
  logic [IDX_LEN-1:0]  wr_idx_s;
  logic [CTR_BITS-1:0] rd_ctr_s;
  logic [CTR_BITS-1:0] wr_ctr_d;
  logic                pred_taken_s;
  logic                mis_predict_s;
  logic                fetch_br_s;

  // Only a slice of each PC feeds the index; the rest is intentionally ignored.
  logic                unused_pc_bits_s;
  assign unused_pc_bits_s = ^{bus.pc_fetch, bus.pc_exe};

  // Lookup and resolve decode: read/write indices, prediction, mispredict flag.
  always_comb begin
    rd_idx_s      = pht_index(bus.pc_fetch[IDX_OFFSET -: IDX_LEN], ghr_q);
    wr_idx_s      = pht_index(bus.pc_exe[IDX_OFFSET -: IDX_LEN], bus.exe_hist);
    // Read sees the registered array, so a same-cycle write is not bypassed.
    rd_ctr_s      = pht_q[rd_idx_s];
    pred_taken_s  = rd_ctr_s[CTR_BITS-1];
    mis_predict_s = bus.exe_valid & (bus.br_en ^ bus.exe_pred_taken);
    fetch_br_s    = bus.fetch_valid & bus.fetch_is_br;
  end

  // Next-state for the trained counter, the history register and statistics.
  always_comb begin
    wr_ctr_d        = ctr_train(pht_q[wr_idx_s], bus.br_en);
    ghr_d           = ghr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;

    // Repair wins: a fetch alongside a mispredict is on the wrong path.
    if (mis_predict_s) begin
      ghr_d = ghr_shift(bus.exe_hist, bus.br_en);
    end else if (fetch_br_s) begin
      ghr_d = ghr_shift(ghr_q, pred_taken_s);
    end else begin
      ghr_d = ghr_q;
    end

    if (bus.exe_valid) begin
      br_count_d = sat_inc32(br_count_q);
    end else begin
      br_count_d = br_count_q;
    end

    if (mis_predict_s) begin
      mispred_count_d = sat_inc32(mispred_count_q);
    end else begin
      mispred_count_d = mispred_count_q;
    end
  end

  // Pattern history table: all entries weakly not-taken on reset, one write per resolve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else begin
      if (bus.exe_valid) begin
        pht_q[wr_idx_s] <= wr_ctr_d;
      end
    end
  end

  // Speculative history and mispredict statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q           <= {GHR_LEN{1'b0}};
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      ghr_q           <= ghr_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bus.pred_taken    = pred_taken_s;
  assign bus.pred_hist     = ghr_q;
  assign bus.mis_predict   = mis_predict_s;
  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Bench for gshare_spec_predictor: two configurations driven with identical
// stimulus and compared every cycle against an arithmetic reference model.
module tb_gshare_spec_predictor;

  logic clk;
  logic rst;

  gshare_spec_predictor_if #(.GHR_LEN(4)) ifa ();
  gshare_spec_predictor_if #(.GHR_LEN(3)) ifb ();

  gshare_spec_predictor #(
    .IDX_OFFSET(6), .IDX_LEN(4), .GHR_LEN(4), .CTR_BITS(2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  gshare_spec_predictor #(
    .IDX_OFFSET(6), .IDX_LEN(6), .GHR_LEN(3), .CTR_BITS(3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model: configuration table plus plain integer state per DUT.
  int m_off   [2] = '{6, 6};
  int m_ilen  [2] = '{4, 6};
  int m_glen  [2] = '{4, 3};
  int m_cbits [2] = '{2, 3};
  int     pht [2][64];
  int     ghr [2];
  longint brc [2];
  longint mpc [2];

  logic   obs_pred [2];
  int     obs_hist [2];
  logic   obs_mis;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input int m, input logic [31:0] pc, input int h);
    logic [31:0] s;
    s = (pc >> (m_off[m] - m_ilen[m] + 1)) & ((32'd1 << m_ilen[m]) - 32'd1);
    return int'(s) ^ h;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      ghr[m] = 0;
      brc[m] = 0;
      mpc[m] = 0;
      for (int i = 0; i < 64; i++) pht[m][i] = (1 << (m_cbits[m] - 1)) - 1;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst A pred",  32'(ifa.pred_taken), 32'd0);
    check_eq("rst A hist",  32'(ifa.pred_hist), 32'd0);
    check_eq("rst A brc",   ifa.br_count, 32'd0);
    check_eq("rst A mpc",   ifa.mispred_count, 32'd0);
    check_eq("rst B pred",  32'(ifb.pred_taken), 32'd0);
    check_eq("rst B hist",  32'(ifb.pred_hist), 32'd0);
    check_eq("rst B brc",   ifb.br_count, 32'd0);
    check_eq("rst B mpc",   ifb.mispred_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: drive both DUTs, check outputs against the model, advance the model.
  task automatic step(input logic fv, input logic fb, input logic [31:0] pcf,
                      input logic ev, input logic [31:0] pce, input int eh,
                      input logic ept, input logic ben);
    int    h_m, ri, wi, top;
    logic  exp_pred, mis, o_pred, o_mis;
    logic [31:0] o_hist, o_brc, o_mpc;
    string nm;
    @(negedge clk);
    ifa.fetch_valid = fv;  ifb.fetch_valid = fv;
    ifa.fetch_is_br = fb;  ifb.fetch_is_br = fb;
    ifa.pc_fetch = pcf;    ifb.pc_fetch = pcf;
    ifa.exe_valid = ev;    ifb.exe_valid = ev;
    ifa.pc_exe = pce;      ifb.pc_exe = pce;
    ifa.exe_hist = 4'(eh); ifb.exe_hist = 3'(eh);
    ifa.exe_pred_taken = ept; ifb.exe_pred_taken = ept;
    ifa.br_en = ben;       ifb.br_en = ben;
    #1;
    mis = ev && (ben != ept);
    for (int m = 0; m < 2; m++) begin
      nm     = (m == 0) ? "A" : "B";
      o_pred = (m == 0) ? ifa.pred_taken : ifb.pred_taken;
      o_hist = (m == 0) ? 32'(ifa.pred_hist) : 32'(ifb.pred_hist);
      o_mis  = (m == 0) ? ifa.mis_predict : ifb.mis_predict;
      o_brc  = (m == 0) ? ifa.br_count : ifb.br_count;
      o_mpc  = (m == 0) ? ifa.mispred_count : ifb.mispred_count;
      obs_pred[m] = o_pred;
      obs_hist[m] = int'(o_hist);
      if (m == 0) obs_mis = o_mis;

      h_m = eh % (1 << m_glen[m]);
      ri  = midx(m, pcf, ghr[m]);
      top = (1 << m_cbits[m]) - 1;
      exp_pred = (pht[m][ri] >= (1 << (m_cbits[m] - 1)));
      check_eq({nm, " pred"}, 32'(o_pred), 32'(exp_pred));
      check_eq({nm, " hist"}, o_hist, 32'(ghr[m]));
      check_eq({nm, " mis"},  32'(o_mis), 32'(mis));
      check_eq({nm, " brc"},  o_brc, 32'(brc[m]));
      check_eq({nm, " mpc"},  o_mpc, 32'(mpc[m]));

      if (ev) begin
        wi = midx(m, pce, h_m);
        if (ben) pht[m][wi] = (pht[m][wi] < top) ? pht[m][wi] + 1 : top;
        else     pht[m][wi] = (pht[m][wi] > 0) ? pht[m][wi] - 1 : 0;
        if (brc[m] < 64'hFFFF_FFFF) brc[m]++;
      end
      if (mis) begin
        ghr[m] = (h_m * 2 + int'(ben)) % (1 << m_glen[m]);
        if (mpc[m] < 64'hFFFF_FFFF) mpc[m]++;
      end else if (fv && fb) begin
        ghr[m] = (ghr[m] * 2 + int'(exp_pred)) % (1 << m_glen[m]);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic [31:0] pcf);
    step(1'b0, 1'b0, pcf, 1'b0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  logic [31:0] pc_pool [4];
  logic [31:0] pcf_r, pce_r;

  initial begin
    rst = 1'b0;
    ifa.fetch_valid = 1'b0; ifb.fetch_valid = 1'b0;
    ifa.fetch_is_br = 1'b0; ifb.fetch_is_br = 1'b0;
    ifa.pc_fetch = 32'h40;  ifb.pc_fetch = 32'h40;
    ifa.exe_valid = 1'b0;   ifb.exe_valid = 1'b0;
    ifa.pc_exe = 32'h0;     ifb.pc_exe = 32'h0;
    ifa.exe_hist = 4'h0;    ifb.exe_hist = 3'h0;
    ifa.exe_pred_taken = 1'b0; ifb.exe_pred_taken = 1'b0;
    ifa.br_en = 1'b0;       ifb.br_en = 1'b0;

    // T1: reset values
    do_reset();
    idle(32'h40);

    // T2: counter saturation upwards then back down (entry 8 in A)
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 0, 1'b1, 1'b1);
      check_eq("T2 up pred", 32'(obs_pred[0]), (i >= 1) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 0, 1'b0, 1'b0);
      check_eq("T2 dn pred", 32'(obs_pred[0]), (i < 2) ? 32'd1 : 32'd0);
    end
    idle(32'h40);
    check_eq("T2 end pred", 32'(obs_pred[0]), 32'd0);

    // T3: train entries 8 and 10, then three speculative fetch branches
    step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    check_eq("T3 br1 pred", 32'(obs_pred[0]), 32'd1);
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    check_eq("T3 br2 pred", 32'(obs_pred[0]), 32'd0);
    check_eq("T3 br2 hist", 32'(obs_hist[0]), 32'd1);
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    check_eq("T3 br3 pred", 32'(obs_pred[0]), 32'd1);
    check_eq("T3 br3 hist", 32'(obs_hist[0]), 32'd2);
    idle(32'h40);
    check_eq("T3 ghr", 32'(obs_hist[0]), 32'd5);

    // T4: set GHR to 0111 via repair, then repair again with a same-cycle fetch
    step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 3, 1'b0, 1'b1);
    idle(32'h40);
    check_eq("T4 pre ghr", 32'(obs_hist[0]), 32'd7);
    step(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 3, 1'b1, 1'b0);
    check_eq("T4 mis", 32'(obs_mis), 32'd1);
    idle(32'h40);
    check_eq("T4 ghr", 32'(obs_hist[0]), 32'd6);

    // T5: read and write of the same entry in one cycle
    step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 6, 1'b1, 1'b1);
    check_eq("T5 old pred", 32'(obs_pred[0]), 32'd0);
    idle(32'h40);
    check_eq("T5 new pred", 32'(obs_pred[0]), 32'd1);

    // T6: wide configuration, counter 3 -> 7 and back, entry 37 read at pc 0x4A
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h4A, 1'b1, 32'h40, 5, 1'b1, 1'b1);
      check_eq("T6 up pred", 32'(obs_pred[1]), (i >= 1) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h4A, 1'b1, 32'h40, 5, 1'b0, 1'b0);
      check_eq("T6 dn pred", 32'(obs_pred[1]), 32'd1);
    end
    idle(32'h4A);
    check_eq("T6 end pred", 32'(obs_pred[1]), 32'd0);

    // Randomised traffic over a small PC pool so entries collide and saturate
    pc_pool[0] = 32'h40; pc_pool[1] = 32'h48; pc_pool[2] = 32'h1C4; pc_pool[3] = 32'h2A;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      pcf_r = ($urandom_range(0, 3) == 0) ? $urandom : pc_pool[$urandom_range(0, 3)];
      pce_r = ($urandom_range(0, 3) == 0) ? $urandom : pc_pool[$urandom_range(0, 3)];
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), pcf_r,
           1'($urandom_range(0, 2) != 0), pce_r, int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
